// File: rtl/sm4_pkg.sv
// SM4 shared definitions: FK constants, round count, FSM encoding.
// Also holds the rotate helper and the arithmetic CK generator.
package sm4_pkg;

  localparam int NROUNDS = 32;

  localparam logic [31:0] FK [4] = '{
    32'hA3B1BAC6,
    32'h56AA3350,
    32'h677D9197,
    32'hB27022DC
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_STREAM
  } state_t;

  function automatic logic [31:0] rol32(
    input logic [31:0] v,
    input int          n
  );
    return (v << n) | (v >> (32 - n));
  endfunction

  // CK_i byte j (MSB first) is 7*(4i+j) mod 256
  function automatic logic [31:0] ck_word(
    input logic [4:0] i
  );
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      w[8*(3-j) +: 8] = 8'(7 * (4 * int'(i) + j));
    end
    return w;
  endfunction

endpackage

// File: rtl/sm4_sbox.sv
// SM4 8-bit substitution box, purely combinational.
// Shared between the key schedule and the cipher rounds.
module sm4_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [7:0] SBOX [256] = '{
    8'hD6,8'h90,8'hE9,8'hFE,8'hCC,8'hE1,8'h3D,8'hB7,
    8'h16,8'hB6,8'h14,8'hC2,8'h28,8'hFB,8'h2C,8'h05,
    8'h2B,8'h67,8'h9A,8'h76,8'h2A,8'hBE,8'h04,8'hC3,
    8'hAA,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9C,8'h42,8'h50,8'hF4,8'h91,8'hEF,8'h98,8'h7A,
    8'h33,8'h54,8'h0B,8'h43,8'hED,8'hCF,8'hAC,8'h62,
    8'hE4,8'hB3,8'h1C,8'hA9,8'hC9,8'h08,8'hE8,8'h95,
    8'h80,8'hDF,8'h94,8'hFA,8'h75,8'h8F,8'h3F,8'hA6,
    8'h47,8'h07,8'hA7,8'hFC,8'hF3,8'h73,8'h17,8'hBA,
    8'h83,8'h59,8'h3C,8'h19,8'hE6,8'h85,8'h4F,8'hA8,
    8'h68,8'h6B,8'h81,8'hB2,8'h71,8'h64,8'hDA,8'h8B,
    8'hF8,8'hEB,8'h0F,8'h4B,8'h70,8'h56,8'h9D,8'h35,
    8'h1E,8'h24,8'h0E,8'h5E,8'h63,8'h58,8'hD1,8'hA2,
    8'h25,8'h22,8'h7C,8'h3B,8'h01,8'h21,8'h78,8'h87,
    8'hD4,8'h00,8'h46,8'h57,8'h9F,8'hD3,8'h27,8'h52,
    8'h4C,8'h36,8'h02,8'hE7,8'hA0,8'hC4,8'hC8,8'h9E,
    8'hEA,8'hBF,8'h8A,8'hD2,8'h40,8'hC7,8'h38,8'hB5,
    8'hA3,8'hF7,8'hF2,8'hCE,8'hF9,8'h61,8'h15,8'hA1,
    8'hE0,8'hAE,8'h5D,8'hA4,8'h9B,8'h34,8'h1A,8'h55,
    8'hAD,8'h93,8'h32,8'h30,8'hF5,8'h8C,8'hB1,8'hE3,
    8'h1D,8'hF6,8'hE2,8'h2E,8'h82,8'h66,8'hCA,8'h60,
    8'hC0,8'h29,8'h23,8'hAB,8'h0D,8'h53,8'h4E,8'h6F,
    8'hD5,8'hDB,8'h37,8'h45,8'hDE,8'hFD,8'h8E,8'h2F,
    8'h03,8'hFF,8'h6A,8'h72,8'h6D,8'h6C,8'h5B,8'h51,
    8'h8D,8'h1B,8'hAF,8'h92,8'hBB,8'hDD,8'hBC,8'h7F,
    8'h11,8'hD9,8'h5C,8'h41,8'h1F,8'h10,8'h5A,8'hD8,
    8'h0A,8'hC1,8'h31,8'h88,8'hA5,8'hCD,8'h7B,8'hBD,
    8'h2D,8'h74,8'hD0,8'h12,8'hB8,8'hE5,8'hB4,8'hB0,
    8'h89,8'h69,8'h97,8'h4A,8'h0C,8'h96,8'h77,8'h7E,
    8'h65,8'hB9,8'hF1,8'h09,8'hC5,8'h6E,8'hC6,8'h84,
    8'h18,8'hF0,8'h7D,8'hEC,8'h3A,8'hDC,8'h4D,8'h20,
    8'h79,8'hEE,8'h5F,8'h3E,8'hD7,8'hCB,8'h39,8'h48
  };

  assign y = SBOX[a];

endmodule

// File: rtl/sm4_key_expand.sv
// SM4 key schedule: expands the master key into 32 round keys,
// stores them, and streams them forward or reverse over valid/ready.
import sm4_pkg::*;

module sm4_key_expand #(
  parameter int SBOX_PAR = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         dec,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [31:0]  rk_data,
  output logic [4:0]   rk_idx,
  output logic         rk_last,
  output logic         done
);

  localparam int NPASS = 4 / SBOX_PAR;
  localparam logic [4:0] LAST_RND = 5'(NROUNDS - 1);

  state_t      state;
  logic [4:0]  rnd;
  logic [1:0]  sub;
  logic        dec_q;
  logic [31:0] k0, k1, k2, k3;
  logic [31:0] b_hold;
  logic [31:0] store [NROUNDS];

  logic [31:0] x;
  logic [31:0] b_cur;
  logic [31:0] rk;
  logic        last_pass;
  logic [4:0]  p_nxt;
  logic [4:0]  p_end;
  logic [7:0]  sin  [SBOX_PAR];
  logic [7:0]  sout [SBOX_PAR];

  function automatic int bsel(
    input logic [1:0] s,
    input int         m
  );
    return int'(s) * SBOX_PAR + m;
  endfunction

  assign x = k1 ^ k2 ^ k3 ^ ck_word(rnd);

  always_comb begin
    for (int m = 0; m < SBOX_PAR; m++) begin
      sin[m] = x[8*(3-bsel(sub, m)) +: 8];
    end
  end

  for (genvar g = 0; g < SBOX_PAR; g++) begin : g_sbox
    sm4_sbox u_sbox (
      .a (sin[g]),
      .y (sout[g])
    );
  end

  // Bytes from earlier passes come from b_hold, this pass from the S-boxes
  always_comb begin
    b_cur = b_hold;
    for (int m = 0; m < SBOX_PAR; m++) begin
      b_cur[8*(3-bsel(sub, m)) +: 8] = sout[m];
    end
  end

  assign rk = k0 ^ b_cur ^ rol32(b_cur, 13) ^ rol32(b_cur, 23);
  assign last_pass = (sub == 2'(NPASS - 1));
  assign p_nxt = dec_q ? rk_idx - 5'd1 : rk_idx + 5'd1;
  assign p_end = dec_q ? 5'd0 : LAST_RND;

  always_ff @(posedge clk) begin
    if (state == S_EXPAND && last_pass) begin
      store[rnd] <= rk;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_last  <= 1'b0;
      done     <= 1'b0;
      rk_data  <= '0;
      rk_idx   <= '0;
      rnd      <= '0;
      sub      <= '0;
      dec_q    <= 1'b0;
      k0       <= '0;
      k1       <= '0;
      k2       <= '0;
      k3       <= '0;
      b_hold   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // the done cycle blocks a back-to-back start
          if (start && !done) begin
            dec_q <= dec;
            k0    <= key_in[127:96] ^ FK[0];
            k1    <= key_in[95:64]  ^ FK[1];
            k2    <= key_in[63:32]  ^ FK[2];
            k3    <= key_in[31:0]   ^ FK[3];
            rnd   <= '0;
            sub   <= '0;
            busy  <= 1'b1;
            state <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          if (!last_pass) begin
            sub    <= sub + 2'd1;
            b_hold <= b_cur;
          end else begin
            sub <= '0;
            k0  <= k1;
            k1  <= k2;
            k2  <= k3;
            k3  <= rk;
            rnd <= rnd + 5'd1;
            if (rnd == LAST_RND) begin
              state    <= S_STREAM;
              rk_valid <= 1'b1;
              rk_last  <= 1'b0;
              if (dec_q) begin
                rk_data <= rk;
                rk_idx  <= LAST_RND;
              end else begin
                rk_data <= store[0];
                rk_idx  <= 5'd0;
              end
            end
          end
        end
        S_STREAM: begin
          if (rk_valid && rk_ready) begin
            if (rk_last) begin
              rk_valid <= 1'b0;
              rk_last  <= 1'b0;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else begin
              rk_data <= store[p_nxt];
              rk_idx  <= p_nxt;
              rk_last <= (p_nxt == p_end);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
